tdm_demux: RTL and testbench
============================

// Module: tdm_demux
// PURPOSE
//   Receive end of a time-division multiplexed word link: one shared data bus
//   carries N_CH channels in fixed slot order, slot 0 flagged by in_sof.
//   Block locks to frame alignment, steers each word to its channel register,
//   flags frame completion and alignment errors. Sits after the TDM link and
//   feeds per-channel consumers.
// PARAMETERS
//   N_CH    4   channels (slots) per frame, >= 2
//   W       8   data word width, bits
// PORTS
//   clk           in   1        single clock, all logic rising-edge
//   rst_n         in   1        asynchronous reset, active-low
//   in_valid      in   1        word present on in_data this cycle
//   in_sof        in   1        word is slot 0 (qualified by in_valid)
//   in_data       in   W        slot word
//   out_data      out  N_CH*W   channel registers, ch i at [i*W +: W]
//   out_ch_valid  out  N_CH     1-cycle pulse: ch i register just updated
//   frame_done    out  1        1-cycle pulse: slot N_CH-1 of aligned frame stored
//   sync_err      out  1        1-cycle pulse: alignment violation detected
//   locked        out  1        1 while in LOCKED state
// BEHAVIOUR
//   Reset (async, rst_n=0): state=HUNT, slot_cnt=0, out_data=0,
//     out_ch_valid=0, frame_done=0, sync_err=0, locked=0. Reset mid-frame
//     drops partial frame; no pulses on release.
//   Latency: all outputs registered; word accepted in cycle t appears on
//     out_data / pulses in cycle t+1. in_valid=0 cycles: nothing changes,
//     pulses deassert.
//   HUNT: in_valid & !in_sof -> word discarded, no pulse.
//     in_valid & in_sof -> write ch0, slot_cnt=1, -> LOCKED.
//   LOCKED, in_valid, slot_cnt=k:
//     !in_sof, k!=0 -> write ch k; if k=N_CH-1 -> frame_done, slot_cnt=0,
//       else slot_cnt=k+1.
//     in_sof, k=0 -> normal slot 0: write ch0, slot_cnt=1.
//     in_sof, k!=0 (early sof) -> sync_err; word taken as slot 0 of new
//       frame: write ch0, slot_cnt=1, stay LOCKED; no frame_done for the
//       truncated frame.
//     !in_sof, k=0 (missing sof) -> sync_err, word dropped, -> HUNT.
//   slot_cnt width $clog2(N_CH); wraps N_CH-1 -> 0 only via frame_done.
//   Untouched channel registers hold value; out_ch_valid one-hot or zero.
//   locked reflects next state (rises with ch0 pulse, falls with sync_err).
// CONFIGURATION
//   TDM_DEMUX_FRAME_CNT_EN defined: extra port frame_cnt out 16, reset 0,
//     +1 (wrapping 16'hFFFF->0) in same cycle frame_done pulses; held
//     across sync_err and HUNT. Undefined: port and counter absent, all
//     other behaviour identical.
// STRUCTURE
//   Package tdm_pkg: typedef enum logic {HUNT, LOCKED} tdm_state_t;
//     default N_CH/W localparams; function slot_w(n) = $clog2(n).
//   Sub-module tdm_slot_counter: slot_cnt register with inc/load1/clear
//     controls and is_last / is_zero flags; top holds FSM and channel regs.
// TESTING
//   1 N_CH=4,W=8: sof+A0, A1, A2, A3 back-to-back -> ch0..3=A0..A3,
//     out_ch_valid 0001,0010,0100,1000 in t+1..t+4, frame_done with 1000,
//     locked=1 from t+1.
//   2 Words 55,66 without sof after reset -> discarded, out_data=0, no
//     pulses, locked=0; then sof+11 -> ch0=11, locked=1.
//   3 Locked, sof+10,20 then sof+30 -> sync_err with ch0 pulse, ch0=30,
//     ch1=20 held, no frame_done; 40,50,60 -> frame_done.
//   4 Full frame done then 77 with in_sof=0 -> sync_err, locked=0, 77
//     not stored; next sof resumes.
//   5 Gaps: sof+01, idle 3 cycles, 02, idle, 03, 04 -> same result as case
//     1 with delays; no pulses in idle cycles.
//   6 Reset asserted after slot 2 -> outputs 0 immediately; with
//     TDM_DEMUX_FRAME_CNT_EN, 3 frames -> frame_cnt=3, reset -> 0.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM receive demultiplexer.
// Holds the alignment state encoding and the slot-counter width helper.
package tdm_pkg;

  typedef enum logic {HUNT, LOCKED} tdm_state_t;

  localparam int N_CH_DEF = 4;
  localparam int W_DEF    = 8;

  function automatic int slot_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot position within the current TDM frame; updates one cycle after a control.
// No backpressure: controls are one-hot by construction, clear wins over load1 over inc.
module tdm_slot_counter import tdm_pkg::*; #(
  parameter int N_CH = N_CH_DEF,
  parameter int SW   = slot_w(N_CH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          load1,
  input  logic          clear,
  output logic [SW-1:0] cnt,
  output logic          is_last,
  output logic          is_zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= SW'(1);
    end else if (inc) begin
      cnt <= cnt + SW'(1);
    end
  end

  assign is_last = (cnt == SW'(N_CH - 1));
  assign is_zero = (cnt == '0);

endmodule

// File: rtl/tdm_demux.sv
// TDM receive demux: locks on in_sof, steers slot words to channel registers, 1-cycle latency.
// No backpressure: every valid word is consumed or dropped in its cycle; TDM_DEMUX_FRAME_CNT_EN adds frame_cnt.
module tdm_demux import tdm_pkg::*; #(
  parameter int N_CH = N_CH_DEF,
  parameter int W    = W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [W-1:0]      in_data,
  output logic [N_CH*W-1:0] out_data,
  output logic [N_CH-1:0]   out_ch_valid,
  output logic              frame_done,
  output logic              sync_err,
  output logic              locked
`ifdef TDM_DEMUX_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  localparam int SW = slot_w(N_CH);

  tdm_state_t      state, state_nxt;
  logic [SW-1:0]   slot_cnt;
  logic            cnt_inc, cnt_load1, cnt_clear;
  logic            cnt_last, cnt_zero;
  logic [N_CH-1:0] wr_ch;
  logic            done_nxt, err_nxt;

  tdm_slot_counter #(.N_CH(N_CH), .SW(SW)) u_slot_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (cnt_inc),
    .load1   (cnt_load1),
    .clear   (cnt_clear),
    .cnt     (slot_cnt),
    .is_last (cnt_last),
    .is_zero (cnt_zero)
  );

  always_comb begin
    state_nxt = state;
    wr_ch     = '0;
    cnt_inc   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_clear = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    if (in_valid) begin
      unique case (state)
        HUNT: begin
          if (in_sof) begin
            wr_ch[0]  = 1'b1;
            cnt_load1 = 1'b1;
            state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (in_sof) begin
            // An early sof truncates the running frame and restarts at slot 0.
            wr_ch[0]  = 1'b1;
            cnt_load1 = 1'b1;
            err_nxt   = !cnt_zero;
          end else if (cnt_zero) begin
            err_nxt   = 1'b1;
            cnt_clear = 1'b1;
            state_nxt = HUNT;
          end else begin
            wr_ch[slot_cnt] = 1'b1;
            if (cnt_last) begin
              done_nxt  = 1'b1;
              cnt_clear = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HUNT;
      out_data     <= '0;
      out_ch_valid <= '0;
      frame_done   <= 1'b0;
      sync_err     <= 1'b0;
    end else begin
      state        <= state_nxt;
      out_ch_valid <= wr_ch;
      frame_done   <= done_nxt;
      sync_err     <= err_nxt;
      for (int i = 0; i < N_CH; i++) begin
        if (wr_ch[i]) out_data[i*W +: W] <= in_data;
      end
    end
  end

  assign locked = (state == LOCKED);

`ifdef TDM_DEMUX_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (done_nxt) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (N_CH=4, W=8); covers frame_cnt when TDM_DEMUX_FRAME_CNT_EN is defined.
module tb_tdm_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_sof;
  logic [7:0]  in_data;
  logic [31:0] out_data;
  logic [3:0]  out_ch_valid;
  logic        frame_done, sync_err, locked;
`ifdef TDM_DEMUX_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tdm_demux #(.N_CH(4), .W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_sof       (in_sof),
    .in_data      (in_data),
    .out_data     (out_data),
    .out_ch_valid (out_ch_valid),
    .frame_done   (frame_done),
    .sync_err     (sync_err),
    .locked       (locked)
`ifdef TDM_DEMUX_FRAME_CNT_EN
    ,
    .frame_cnt    (frame_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] d, input logic [3:0] chv,
                     input logic fd, input logic se, input logic lk);
    check({tag, ".data"},   out_data,            d);
    check({tag, ".chv"},    {28'd0, out_ch_valid}, {28'd0, chv});
    check({tag, ".fdone"},  {31'd0, frame_done}, {31'd0, fd});
    check({tag, ".serr"},   {31'd0, sync_err},   {31'd0, se});
    check({tag, ".locked"}, {31'd0, locked},     {31'd0, lk});
  endtask

  // Drive one cycle of input, then sample 1 time unit after the capturing edge.
  task automatic step(input logic v, input logic s, input logic [7:0] d);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", 32'h0, 4'b0000, 0, 0, 0);
    rst_n = 1'b1;

    // Words without sof are discarded while hunting
    step(1, 0, 8'h55); chk("hunt55", 32'h0, 4'b0000, 0, 0, 0);
    step(1, 0, 8'h66); chk("hunt66", 32'h0, 4'b0000, 0, 0, 0);
    step(1, 1, 8'h11); chk("lock11", 32'h00000011, 4'b0001, 0, 0, 1);
    step(1, 0, 8'h22); chk("f0s1",   32'h00002211, 4'b0010, 0, 0, 1);
    step(1, 0, 8'h33); chk("f0s2",   32'h00332211, 4'b0100, 0, 0, 1);
    step(1, 0, 8'h44); chk("f0s3",   32'h44332211, 4'b1000, 1, 0, 1);

    // Back-to-back full frame
    step(1, 1, 8'hA0); chk("f1s0", 32'h443322A0, 4'b0001, 0, 0, 1);
    step(1, 0, 8'hA1); chk("f1s1", 32'h4433A1A0, 4'b0010, 0, 0, 1);
    step(1, 0, 8'hA2); chk("f1s2", 32'h44A2A1A0, 4'b0100, 0, 0, 1);
    step(1, 0, 8'hA3); chk("f1s3", 32'hA3A2A1A0, 4'b1000, 1, 0, 1);

    // Early sof truncates the frame
    step(1, 1, 8'h10); chk("e_s0",  32'hA3A2A110, 4'b0001, 0, 0, 1);
    step(1, 0, 8'h20); chk("e_s1",  32'hA3A22010, 4'b0010, 0, 0, 1);
    step(1, 1, 8'h30); chk("early", 32'hA3A22030, 4'b0001, 0, 1, 1);
    step(1, 0, 8'h40); chk("e_n1",  32'hA3A24030, 4'b0010, 0, 0, 1);
    step(1, 0, 8'h50); chk("e_n2",  32'hA3504030, 4'b0100, 0, 0, 1);
    step(1, 0, 8'h60); chk("e_n3",  32'h60504030, 4'b1000, 1, 0, 1);

    // Missing sof drops the word and loses lock
    step(1, 0, 8'h77); chk("miss",  32'h60504030, 4'b0000, 0, 1, 0);
    step(1, 0, 8'h88); chk("hunt88", 32'h60504030, 4'b0000, 0, 0, 0);
    step(1, 1, 8'h91); chk("r_s0",  32'h60504091, 4'b0001, 0, 0, 1);
    step(1, 0, 8'h92); chk("r_s1",  32'h60509291, 4'b0010, 0, 0, 1);
    step(1, 0, 8'h93); chk("r_s2",  32'h60939291, 4'b0100, 0, 0, 1);
    step(1, 0, 8'h94); chk("r_s3",  32'h94939291, 4'b1000, 1, 0, 1);

    // Idle gaps inside a frame
    step(1, 1, 8'h01); chk("g_s0",  32'h94939201, 4'b0001, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 8'hEE); chk("g_idle", 32'h94939201, 4'b0000, 0, 0, 1);
    end
    step(1, 0, 8'h02); chk("g_s1",  32'h94930201, 4'b0010, 0, 0, 1);
    step(0, 1, 8'hEE); chk("g_id2", 32'h94930201, 4'b0000, 0, 0, 1);
    step(1, 0, 8'h03); chk("g_s2",  32'h94030201, 4'b0100, 0, 0, 1);
    step(1, 0, 8'h04); chk("g_s3",  32'h04030201, 4'b1000, 1, 0, 1);
`ifdef TDM_DEMUX_FRAME_CNT_EN
    check("fcnt5", {16'd0, frame_cnt}, 32'd5);
`endif

    // Reset mid-frame clears outputs immediately
    step(1, 1, 8'hC1); chk("m_s0", 32'h040302C1, 4'b0001, 0, 0, 1);
    step(1, 0, 8'hC2); chk("m_s1", 32'h0403C2C1, 4'b0010, 0, 0, 1);
    step(1, 0, 8'hC3); chk("m_s2", 32'h04C3C2C1, 4'b0100, 0, 0, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst", 32'h0, 4'b0000, 0, 0, 0);
`ifdef TDM_DEMUX_FRAME_CNT_EN
    check("fcnt_rst", {16'd0, frame_cnt}, 32'd0);
`endif
    step(0, 0, 8'h00);
    rst_n = 1'b1;
    step(0, 0, 8'h00); chk("post_rst", 32'h0, 4'b0000, 0, 0, 0);
    step(1, 0, 8'hC4); chk("post_hunt", 32'h0, 4'b0000, 0, 0, 0);

`ifdef TDM_DEMUX_FRAME_CNT_EN
    for (int f = 0; f < 3; f++) begin
      step(1, 1, 8'hD0);
      step(1, 0, 8'hD1);
      step(1, 0, 8'hD2);
      step(1, 0, 8'hD3);
    end
    check("fcnt3", {16'd0, frame_cnt}, 32'd3);
    step(1, 0, 8'hD4);
    check("fcnt_hold", {16'd0, frame_cnt}, 32'd3);
`endif

    step(0, 0, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
